pipe_reg_chain: RTL



---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_stage.sv | 54 +++++
 rtl/pipe_reg_chain.sv | 98 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants and helpers for the pipeline register chain
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Deepest chain the block is sized and characterised for.
    localparam int MAX_DEPTH = 8;

    // Default value loaded into every data register on reset.
    localparam logic [63:0] PIPE_RST_VAL = 64'h0;

    // Number of bits needed to encode values 0..value-1 (ceil(log2(value))).
    // Occupancy counts 0..DEPTH, so callers pass DEPTH+1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_stage.sv
// ============================================================================
//  Module      : pipe_stage
//  Description : One pipeline stage: a valid flop plus a WIDTH-bit data flop,
//                with asynchronous active-low reset and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Valid bit: flush wins over any load; otherwise follow the upstream
    // valid whenever the stage is allowed to advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= valid_in;
        end
    end

    // Payload: only captured when a real word arrives. Bubbles leave the
    // old contents in place (data is don't-care while invalid), which avoids
    // needless toggling of wide registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= RESET_VAL;
        end else if (load && valid_in && !flush) begin
            r_data <= data_in;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule : pipe_stage

`default_nettype wire

// File: rtl/pipe_reg_chain.sv
// ============================================================================
//  Module      : pipe_reg_chain
//  Description : DEPTH-stage, WIDTH-bit pipeline register chain with
//                valid/ready handshake, bubble collapsing, back-pressure
//                stall, synchronous flush and an occupancy count.
//                Stage 0 is the input side, stage DEPTH-1 drives the output.
//                DEPTH must lie in 1..MAX_DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RST_VAL)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int OCC_W = clog2(DEPTH + 1);

    logic [DEPTH-1:0] w_v;          // per-stage valid bits
    logic [DEPTH-1:0] w_adv;        // per-stage advance (load) enables
    logic [DEPTH-1:0] w_vin;        // valid presented to each stage
    logic [WIDTH-1:0] w_d   [DEPTH];
    logic [WIDTH-1:0] w_din [DEPTH];
    logic [OCC_W-1:0] w_occ;

    // Advance chain, evaluated from the output side backwards: a stage may
    // load when it is empty or when the stage after it is moving. Empty
    // stages therefore always absorb the word behind them (bubble collapse).
    always_comb begin
        w_adv            = '0;
        w_adv[DEPTH-1]   = !w_v[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = !w_v[i] | w_adv[i+1];
        end
    end

    // Stage array: stage 0 takes the upstream handshake, every later stage
    // takes the contents of its predecessor.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign w_vin[gi] = in_valid;
                assign w_din[gi] = in_data;
            end else begin : g_rest
                assign w_vin[gi] = w_v[gi-1];
                assign w_din[gi] = w_d[gi-1];
            end

            pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (flush),
                .load     (w_adv[gi]),
                .valid_in (w_vin[gi]),
                .data_in  (w_din[gi]),
                .valid    (w_v[gi]),
                .data     (w_d[gi])
            );
        end
    endgenerate

    // Occupancy is the popcount of the registered valid bits, so it moves by
    // exactly one on an input-only or output-only transfer and not at all
    // when both or neither happen.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(w_v[i]);
        end
    end

    // Flush blocks acceptance in its own cycle: the flushed edge clears
    // every stage, so an accepted word would be silently lost.
    assign in_ready  = w_adv[0] & !flush;
    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];
    assign occupancy = w_occ;

endmodule : pipe_reg_chain

`default_nettype wire
